core_traffic_gen: RTL
=====================

// Module: core_traffic_gen
// PURPOSE
//  Synthesizable, parametrised per-core request generator for the MESI coherence test system.
//  Issues a seeded pseudo-random stream of line reads/writes into one L1 cache port.
//  Counts completed ops and flags response timeouts; needs no test-vector files.
//  One instance per core; N instances drive the coherent caches concurrently.
// PARAMETERS
//  ID          0              core index; seeds LFSR, tags write data
//  NUM_OPS     256            transactions per run (>=1)
//  ADDR_BITS   4              line-index bits; 2**ADDR_BITS distinct lines exercised
//  WRITE_THRESH 8'd128        op is write when lfsr[15:8] < WRITE_THRESH (0=all reads, 255~all writes)
//  GAP_BITS    2              idle gap before each op = lfsr[24 +: GAP_BITS] cycles
//  TIMEOUT     50             cycles in REQ without cpu_resp before error sets
//  SEED        32'h0000_ACE1  LFSR seed; effective seed = SEED ^ ID, forced nonzero (0 -> 32'h1)
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 async reset, active-high
//  start      in   1                 1-cycle pulse; starts run from IDLE or DONE
//  busy       out  1                 run in progress
//  done       out  1                 NUM_OPS ops completed; held until start/rst
//  error      out  1                 sticky: some op exceeded TIMEOUT
//  ops_done   out  $clog2(NUM_OPS+1) completed op count
//  cpu_ready  in   1                 cache can accept a request
//  cpu_resp   in   1                 cache completes current request (1-cycle pulse)
//  cpu_rdata  in   CACHELINE_SIZE    read data (sampled by stats only)
//  cpu_req    out  1                 request valid
//  cpu_we     out  1                 1 = write
//  cpu_addr   out  XLEN              line-aligned address
//  cpu_wdata  out  CACHELINE_SIZE    write data; 0 on reads
// BEHAVIOUR
//  Reset (async): FSM=IDLE; busy/done/error=0; ops_done=0; cpu_req/we/addr/wdata=0; LFSR=eff. seed.
//  FSM states (tg_state_t): TG_IDLE, TG_GAP, TG_REQ, TG_DONE.
//   IDLE/DONE --start--> GAP: LFSR reloads seed; ops_done, error, gap counter cleared.
//   GAP: gap counter counts down; when 0 and cpu_ready=1 -> REQ. LFSR steps once on this transition.
//   REQ: cpu_req=1; we/addr/wdata are registered and held stable until cpu_resp.
//     cpu_resp=1 -> ops_done++. If ops_done+1==NUM_OPS -> DONE, else -> GAP with new gap.
//     cpu_req deasserts the cycle after cpu_resp.
//  Op decode (post-step LFSR value L): addr = {'0, L[ADDR_BITS-1:0], {OFS{1'b0}}},
//   OFS = $clog2(CACHELINE_SIZE/8); we = (L[15:8] < WRITE_THRESH).
//   wdata = {ID[7:0], op_index[23:0]} replicated CACHELINE_SIZE/32 times.
//  LFSR: 32-bit Galois, mask 32'h8020_0003; step only on GAP->REQ transition.
//  Timeout: cycle counter runs in REQ and clears on entry. Reaching TIMEOUT sets error (sticky).
//   The FSM keeps waiting with req held; the protocol is never abandoned.
//  busy = GAP|REQ; done = DONE.
//  start while busy: ignored. cpu_resp outside REQ: ignored.
//  cpu_resp in the same cycle as the TIMEOUT hit: op completes and error still sets.
//  Reset mid-REQ: req drops immediately; the cache side must tolerate this.
// CONFIGURATION
//  TG_LATENCY_STATS_EN defined: adds outputs lat_max[15:0] and lat_sum[31:0].
//   Latency = cycles from REQ entry to cpu_resp. Both saturate and clear on start/rst.
//   Also adds rd_xor[CACHELINE_SIZE-1:0] = XOR of all cpu_rdata for reads, for signature compare.
//  Undefined: these ports and their logic are absent; other behaviour is identical.
// STRUCTURE
//  types package: tg_state_t enum; TG_LFSR_MASK constant; reuse XLEN, CACHELINE_SIZE.
//  Sub-module tg_lfsr: params WIDTH=32, MASK; ports clk, rst, load, seed, step, value.
// TESTING
//  1 Reset mid-REQ (ADDR_BITS=2) -> cpu_req=0 the same cycle, busy=0; ops_done=0 after release.
//  2 NUM_OPS=4, GAP_BITS=0, 1-cycle-latency cache, start -> exactly 4 req/resp pairs,
//    done=1, ops_done=4; addr[63:0] of each op matches the reference LFSR model.
//  3 WRITE_THRESH=0 -> all 4 ops have we=0, wdata=0.
//    WRITE_THRESH=255, ID=3: op 2 wdata = {8'h03,24'h000002} repeated.
//  4 Cache holds cpu_ready=0 for 10 cycles -> no cpu_req until ready rises; LFSR not stepped.
//  5 Cache withholds resp 60 cycles (TIMEOUT=50) -> error=1 at cycle 50, req held;
//    resp at cycle 60 completes the op; the error clears on the next start.
//  6 start pulse while busy -> ignored. Two runs with the same SEED/ID -> identical addr/we sequences.

Source files
------------

// File: rtl/core_traffic_gen_pkg.sv
// core_traffic_gen_pkg: shared types and constants for the per-core traffic generator.
//   XLEN / CACHELINE_SIZE : system address width and cache line width in bits
//   tg_state_t            : generator FSM states
//   TG_LFSR_MASK          : Galois feedback mask of the op-stream LFSR
//   tg_lfsr_next()        : one LFSR step, used to decode the op being issued
//   tg_eff_seed()         : SEED ^ ID with the all-zero lock-up state avoided
package core_traffic_gen_pkg;

    localparam int unsigned XLEN           = 64;
    localparam int unsigned CACHELINE_SIZE = 512;

    localparam logic [31:0] TG_LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        TG_IDLE,
        TG_GAP,
        TG_REQ,
        TG_DONE
    } tg_state_t;

    function automatic logic [31:0] tg_lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TG_LFSR_MASK) : (v >> 1);
    endfunction

    function automatic logic [31:0] tg_eff_seed(input logic [31:0] seed, input logic [31:0] id);
        logic [31:0] s;
        s = seed ^ id;
        return (s == '0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/tg_lfsr.sv
// tg_lfsr: right-shifting Galois LFSR with synchronous load and step enable.
//   clk, rst : clock, asynchronous active-high reset (state := seed)
//   load     : reload state from seed (wins over step)
//   seed     : reload / reset value
//   step     : advance one position
//   value    : current state
module tg_lfsr
    import core_traffic_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] MASK  = WIDTH'(TG_LFSR_MASK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            value_d = value_q[0] ? ((value_q >> 1) ^ MASK) : (value_q >> 1);
        end
    end

    // seed is tied to a constant by the parent, so this is a plain preset flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/core_traffic_gen.sv
// core_traffic_gen: seeded pseudo-random line read/write generator for one L1 cache port.
//   start/busy/done  : run control; done holds until the next start or reset
//   error            : sticky, some request waited TIMEOUT cycles without a response
//   ops_done         : completed op count for the current run
//   cpu_ready/resp   : cache accept and 1-cycle completion pulse
//   cpu_rdata        : read data, only consumed by the optional statistics
//   cpu_req/we/addr/wdata : registered request, held stable until cpu_resp
// Optional build macro TG_LATENCY_STATS_EN adds lat_max, lat_sum and rd_xor outputs.
module core_traffic_gen
    import core_traffic_gen_pkg::*;
#(
    parameter int unsigned ID           = 0,
    parameter int unsigned NUM_OPS      = 256,
    parameter int unsigned ADDR_BITS    = 4,
    parameter logic [7:0]  WRITE_THRESH = 8'd128,
    parameter int unsigned GAP_BITS     = 2,
    parameter int unsigned TIMEOUT      = 50,
    parameter logic [31:0] SEED         = 32'h0000_ACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(NUM_OPS+1)-1:0]   ops_done,
    input  logic                           cpu_ready,
    input  logic                           cpu_resp,
    input  logic [CACHELINE_SIZE-1:0]      cpu_rdata,
    output logic                           cpu_req,
    output logic                           cpu_we,
    output logic [XLEN-1:0]                cpu_addr,
    output logic [CACHELINE_SIZE-1:0]      cpu_wdata
`ifdef TG_LATENCY_STATS_EN
    ,
    output logic [15:0]                    lat_max,
    output logic [31:0]                    lat_sum,
    output logic [CACHELINE_SIZE-1:0]      rd_xor
`endif
);

    localparam int unsigned OPS_W    = $clog2(NUM_OPS + 1);
    localparam int unsigned OFS      = $clog2(CACHELINE_SIZE / 8);
    localparam int unsigned GW       = (GAP_BITS > 0) ? GAP_BITS : 1;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned WORDS    = CACHELINE_SIZE / 32;
    localparam logic [31:0] EFF_SEED = tg_eff_seed(SEED, 32'(ID));
    localparam logic [OPS_W-1:0] LAST_OP  = OPS_W'(NUM_OPS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]  ID_TAG   = 8'(ID);

    tg_state_t                 state_q, state_d;
    logic [OPS_W-1:0]          ops_done_q, ops_done_d;
    logic                      error_q, error_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      cpu_req_q, cpu_req_d;
    logic                      cpu_we_q, cpu_we_d;
    logic [XLEN-1:0]           cpu_addr_q, cpu_addr_d;
    logic [CACHELINE_SIZE-1:0] cpu_wdata_q, cpu_wdata_d;

    logic        lfsr_load, lfsr_step;
    logic [31:0] lfsr_value, lfsr_next;
    logic [31:0] op_word;
    logic [GW-1:0] gap_next;

    tg_lfsr #(
        .WIDTH (32),
        .MASK  (TG_LFSR_MASK)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (EFF_SEED),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // The op is decoded from the value the LFSR is stepping to, so the request
    // fields and the LFSR update land on the same edge.
    assign lfsr_next = tg_lfsr_next(lfsr_value);
    assign op_word   = {ID_TAG, 24'(ops_done_q)};
    // In REQ the LFSR already holds the current op's value; its top bits set the next gap.
    assign gap_next  = (GAP_BITS == 0) ? '0 : lfsr_value[24 +: GW];

    always_comb begin
        state_d     = state_q;
        ops_done_d  = ops_done_q;
        error_d     = error_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        cpu_req_d   = 1'b0;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        case (state_q)
            TG_IDLE, TG_DONE: begin
                if (start) begin
                    state_d    = TG_GAP;
                    lfsr_load  = 1'b1;
                    ops_done_d = '0;
                    error_d    = 1'b0;
                    gap_d      = '0;
                end
            end
            TG_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (cpu_ready) begin
                    state_d     = TG_REQ;
                    lfsr_step   = 1'b1;
                    tmo_d       = '0;
                    cpu_req_d   = 1'b1;
                    cpu_we_d    = (lfsr_next[15:8] < WRITE_THRESH);
                    cpu_addr_d  = XLEN'(lfsr_next[ADDR_BITS-1:0]) << OFS;
                    cpu_wdata_d = cpu_we_d ? {WORDS{op_word}} : '0;
                end
            end
            TG_REQ: begin
                cpu_req_d = 1'b1;
                // Counter parks at the hit value; the request is never abandoned.
                if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (cpu_resp) begin
                    cpu_req_d   = 1'b0;
                    cpu_we_d    = 1'b0;
                    cpu_addr_d  = '0;
                    cpu_wdata_d = '0;
                    ops_done_d  = ops_done_q + OPS_W'(1);
                    if (ops_done_q == LAST_OP) begin
                        state_d = TG_DONE;
                    end else begin
                        state_d = TG_GAP;
                        gap_d   = gap_next;
                    end
                end
            end
            default: state_d = TG_IDLE;
        endcase

        busy_d = (state_d == TG_GAP) || (state_d == TG_REQ);
        done_d = (state_d == TG_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TG_IDLE;
            ops_done_q  <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gap_q       <= '0;
            tmo_q       <= '0;
            cpu_req_q   <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ops_done_q  <= ops_done_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            cpu_req_q   <= cpu_req_d;
            cpu_we_q    <= cpu_we_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign ops_done  = ops_done_q;
    assign cpu_req   = cpu_req_q;
    assign cpu_we    = cpu_we_q;
    assign cpu_addr  = cpu_addr_q;
    assign cpu_wdata = cpu_wdata_q;

`ifdef TG_LATENCY_STATS_EN
    logic [15:0]               lat_cnt_q, lat_cnt_d, lat_max_q, lat_max_d, lat_now;
    logic [31:0]               lat_sum_q, lat_sum_d;
    logic [32:0]               sum_ext;
    logic [CACHELINE_SIZE-1:0] rd_xor_q, rd_xor_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        lat_max_d = lat_max_q;
        lat_sum_d = lat_sum_q;
        rd_xor_d  = rd_xor_q;
        // Latency counts edges from REQ entry up to and including the resp edge.
        lat_now   = (lat_cnt_q == 16'hFFFF) ? lat_cnt_q : lat_cnt_q + 16'd1;
        sum_ext   = {1'b0, lat_sum_q} + 33'(lat_now);
        if ((state_q == TG_IDLE || state_q == TG_DONE) && start) begin
            lat_cnt_d = '0;
            lat_max_d = '0;
            lat_sum_d = '0;
            rd_xor_d  = '0;
        end else if (state_q == TG_GAP && state_d == TG_REQ) begin
            lat_cnt_d = '0;
        end else if (state_q == TG_REQ) begin
            lat_cnt_d = lat_now;
            if (cpu_resp) begin
                if (lat_now > lat_max_q) begin
                    lat_max_d = lat_now;
                end
                lat_sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
                if (!cpu_we_q) begin
                    rd_xor_d = rd_xor_q ^ cpu_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q <= '0;
            lat_max_q <= '0;
            lat_sum_q <= '0;
            rd_xor_q  <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            lat_max_q <= lat_max_d;
            lat_sum_q <= lat_sum_d;
            rd_xor_q  <= rd_xor_d;
        end
    end

    assign lat_max = lat_max_q;
    assign lat_sum = lat_sum_q;
    assign rd_xor  = rd_xor_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^cpu_rdata;
`endif

endmodule
